// File: rtl/fetch_unit.sv
//==============================================================================
// Module      : fetch_unit
// Description : Dual-issue instruction fetch front end. Fetches two words per
//               cycle from instruction memory into a circular instruction
//               queue of {instruction, pc} entries, redirects on branch_taken
//               and hands the queue head to decode.
//               Optional feature macro: FETCH_PERF_EN (fetch/stall counters).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module fetch_unit #(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [`ADDR_WIDTH-1:0] pc,
    input  logic [`INST_WIDTH-1:0] instruction0,
    input  logic [`INST_WIDTH-1:0] instruction1,
    input  logic                   branch_taken,
    input  logic [`ADDR_WIDTH-1:0] branch_target,
    input  logic                   deq_ready,
    output logic                   out_valid,
    output logic [`INST_WIDTH-1:0] out_instruction,
    output logic [`ADDR_WIDTH-1:0] out_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]            fetch_count,
    output logic [31:0]            stall_count,
`endif
    output logic                   full,
    output logic                   empty
);

    localparam int AW    = `ADDR_WIDTH;
    localparam int IW    = `INST_WIDTH;
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Queue storage: no reset needed, entries are qualified by count.
    logic [IW-1:0]    q_inst [QUEUE_DEPTH];
    logic [AW-1:0]    q_pc   [QUEUE_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [CNT_W-1:0] free;
    logic [1:0]       enq_count;
    logic             deq;
    logic             we0;
    logic             we1;
    logic [PTR_W-1:0] wr_ptr1;

    // Enqueue/dequeue decisions, all derived from the start-of-cycle count.
    always_comb begin
        free      = CNT_W'(QUEUE_DEPTH) - count;
        enq_count = 2'd0;
        if (!branch_taken) begin
            if (free >= CNT_W'(2))
                enq_count = 2'd2;
            else if (free == CNT_W'(1))
                enq_count = 2'd1;
        end
        deq     = !branch_taken && (count != '0) && deq_ready;
        we0     = !reset && (enq_count != 2'd0);
        we1     = !reset && (enq_count == 2'd2);
        wr_ptr1 = wr_ptr + PTR_W'(1);
    end

    // Queue entry writes: instruction0 first, instruction1 in the next slot.
    always_ff @(posedge clk) begin
        if (we0) begin
            q_inst[wr_ptr] <= instruction0;
            q_pc[wr_ptr]   <= pc;
        end
        if (we1) begin
            q_inst[wr_ptr1] <= instruction1;
            q_pc[wr_ptr1]   <= pc + AW'(1);
        end
    end

    // Fetch address, pointers and occupancy; redirect flushes the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (branch_taken) begin
            pc     <= branch_target;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            pc     <= pc + AW'(enq_count);
            wr_ptr <= wr_ptr + PTR_W'(enq_count);
            rd_ptr <= rd_ptr + PTR_W'(deq);
            count  <= count + CNT_W'(enq_count) - CNT_W'(deq);
        end
    end

`ifdef FETCH_PERF_EN
    // Performance counters: instructions enqueued and full-queue stall cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else if (!branch_taken) begin
            fetch_count <= fetch_count + 32'(enq_count);
            if (free == '0)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

    // Head-of-queue view and status flags, zeroed while the queue is empty.
    always_comb begin
        out_valid       = (count != '0);
        out_instruction = out_valid ? q_inst[rd_ptr] : '0;
        out_pc          = out_valid ? q_pc[rd_ptr]   : '0;
        full            = (count == CNT_W'(QUEUE_DEPTH));
        empty           = (count == '0);
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4: instruction queue entries; power of two, at least 2.
REQ-002 SHALL use the existing `ADDR_WIDTH and `INST_WIDTH macros for all address and instruction widths.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pc  output  `ADDR_WIDTH  fetch address presented to instruction_memory.
REQ-006 SHALL have port instruction0  input  `INST_WIDTH  instruction memory word at pc.
REQ-007 SHALL have port instruction1  input  `INST_WIDTH  instruction memory word at pc+1.
REQ-008 SHALL have port branch_taken  input  1  redirect request from execute.
REQ-009 SHALL have port branch_target  input  `ADDR_WIDTH  redirect address; valid when branch_taken=1.
REQ-010 SHALL have port deq_ready  input  1  decode accepts the head entry this cycle.
REQ-011 SHALL have port out_valid  output  1  queue head holds a valid instruction.
REQ-012 SHALL have port out_instruction  output  `INST_WIDTH  head instruction; 0 when out_valid=0.
REQ-013 SHALL have port out_pc  output  `ADDR_WIDTH  address of head instruction; 0 when out_valid=0.
REQ-014 SHALL have ports full and empty  output  1  each: count==QUEUE_DEPTH and count==0.

Function
REQ-015 SHALL hold a circular FIFO of {instruction, pc} entries with read/write pointers wrapping modulo QUEUE_DEPTH and a count of width log2(QUEUE_DEPTH)+1.
REQ-016 SHALL compute free = QUEUE_DEPTH - count from the start-of-cycle count; same-cycle dequeue does not create space.
REQ-017 SHALL, when free>=2 and no redirect: enqueue {instruction0,pc} then {instruction1,pc+1} in order; pc <= pc+2.
REQ-018 SHALL, when free==1 and no redirect: enqueue {instruction0,pc} only; pc <= pc+1.
REQ-019 SHALL, when free==0 and no redirect: enqueue nothing; pc holds.
REQ-020 SHALL dequeue the head when out_valid=1 and deq_ready=1; deq_ready with out_valid=0 has no effect.
REQ-021 SHALL allow simultaneous enqueue and dequeue; count <= count + enq_count - deq_count.
REQ-022 SHALL drive out_valid, out_instruction and out_pc from registered queue state; an entry written at the end of cycle N is visible at the outputs in cycle N+1.
REQ-023 SHALL, on branch_taken=1: empty the queue (count, pointers to 0), set pc <= branch_target, perform no enqueue, and ignore any dequeue that cycle.
REQ-024 SHALL wrap pc, pc+1 and pc+2 modulo 2^`ADDR_WIDTH without error.

Reset
REQ-025 SHALL, when reset=1 at a clock edge: set pc=0, count=0, both pointers=0, out_valid=0, out_instruction=0, out_pc=0, empty=1, full=0; reset overrides branch_taken and deq_ready.
REQ-026 SHALL discard all queued entries when reset asserts mid-operation; fetch restarts at pc=0 in the first cycle after reset deasserts.

Configuration
REQ-027 SHALL, with FETCH_PERF_EN defined: add output fetch_count (32 bits) counting instructions enqueued (+0/1/2 per cycle) and output stall_count (32 bits) counting cycles with free==0 and no redirect; both reset to 0 and wrap at 2^32.
REQ-028 SHALL, without FETCH_PERF_EN: omit both ports and all counter logic; all other behaviour is identical.

Verification
REQ-029 SHALL cover: reset, then deq_ready=0 with QUEUE_DEPTH=4 -> pc 0,2,4 over three cycles; full=1 from cycle 3; pc holds at 4; out_pc=0 throughout.
REQ-030 SHALL cover: deq_ready=1 continuously from reset -> out_valid first in cycle 2; out_pc sequence 0,1,2,3,... with no gaps; count never reaches 4.
REQ-031 SHALL cover: count=3 with deq_ready=1 -> only instruction0 enqueued; pc advances by 1; count stays 3.
REQ-032 SHALL cover: queue holding 3 entries, branch_taken=1 with target 0x40 -> next cycle empty=1, pc=0x40; the following cycle out_valid=1 with out_pc=0x40.
REQ-033 SHALL cover: reset pulse while full at pc=0x10 -> next cycle empty=1, pc=0, out_valid=0; with FETCH_PERF_EN, both counters read 0.
REQ-034 SHALL cover: pc=2^`ADDR_WIDTH-2 with free>=2 -> out_pc of the enqueued entries = 2^`ADDR_WIDTH-2 and 2^`ADDR_WIDTH-1; next pc=0.
